// File: rtl/alu_flags_seq.sv
// Slice-serial ALU: add/sub/and/or/xor/slt on WIDTH-bit operands, SLICE bits per cycle, with Z/C/V/N flags.
// Latency: done pulses NSLICE cycles after an accepted start (NSLICE+1 for slt); result/flags change only on entering DONE.
// Backpressure: start is accepted only in IDLE; starts while busy or in DONE are dropped; abort cancels RUN/FIX with no done.
module alu_flags_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             N
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched operands are shifted right each slice so slice k always sits in the low bits.
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             slt_lt;

  logic             is_sub, is_slt, is_logic, is_arith, is_last;
  logic [SLICE-1:0] a_k, b_k, beff_k, slice_res;
  logic [SLICE:0]   sum;
  logic             v_calc;
  logic [WIDTH-1:0] acc_next, slt_word;
  logic             accept;

  assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign is_slt   = (op_q == OP_SLT);
  assign is_logic = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
  assign is_arith = !is_logic && !is_slt;
  assign is_last  = (cnt == CW'(NSLICE - 1));
  assign accept   = start && !abort;

  assign a_k    = a_sh[SLICE-1:0];
  assign b_k    = b_sh[SLICE-1:0];
  assign beff_k = is_sub ? ~b_k : b_k;
  assign sum    = {1'b0, a_k} + {1'b0, beff_k} + {{SLICE{1'b0}}, carry};

  // Overflow is only meaningful on the top slice, where a_k/beff_k/sum hold the operand msbs.
  assign v_calc = (a_k[SLICE-1] ~^ beff_k[SLICE-1]) & (sum[SLICE-1] ^ a_k[SLICE-1]);

  // Per-slice result selection; unused opcodes fall through to add.
  always_comb begin
    slice_res = sum[SLICE-1:0];
    case (op_q)
      OP_AND:  slice_res = a_k & b_k;
      OP_OR:   slice_res = a_k | b_k;
      OP_XOR:  slice_res = a_k ^ b_k;
      default: slice_res = sum[SLICE-1:0];
    endcase
  end

  // New slice enters at the top of the accumulator so the word is aligned after NSLICE steps.
  assign acc_next = (acc >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
  assign slt_word = WIDTH'(slt_lt);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort)        state_next = S_IDLE;
        else if (is_last) state_next = is_slt ? S_FIX : S_DONE;
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, slice stepping, and result/flag commit on the edge entering DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      slt_lt <= 1'b0;
      result <= '0;
      Z      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
      N      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= alucontrol;
            acc   <= '0;
            cnt   <= '0;
            carry <= (alucontrol == OP_SUB) || (alucontrol == OP_SLT);
          end
        end
        S_RUN: begin
          if (!abort) begin
            a_sh  <= a_sh >> SLICE;
            b_sh  <= b_sh >> SLICE;
            acc   <= acc_next;
            carry <= sum[SLICE];
            cnt   <= cnt + CW'(1);
            if (is_last) begin
              slt_lt <= sum[SLICE-1] ^ v_calc;
              if (!is_slt) begin
                result <= acc_next;
                Z      <= (acc_next == '0);
                N      <= acc_next[WIDTH-1];
                C      <= is_arith & sum[SLICE];
                V      <= is_arith & v_calc;
              end
            end
          end
        end
        S_FIX: begin
          if (!abort) begin
            result <= slt_word;
            Z      <= ~slt_lt;
            N      <= slt_word[WIDTH-1];
            C      <= 1'b0;
            V      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
